m68k_bus_master: RTL and testbench

Bus-cycle initiator for the NeoGeo 68K-side bus. It turns a single-word read or write request from an internal client (debug/DMA/test logic) into an asynchronous-style 68000 bus cycle: nAS, nUDS/nLDS, RW, address, and data. It then waits on nDTACK from the wait-state/DTACK logic and returns read data or a timeout error. It sits between the client and the bus decode that produces nDTACK.

---
 rtl/m68k_bus_master.sv | 143 ++++++++++++++
 tb/tb_m68k_bus_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_master.sv
// Single-word 68000 bus-cycle initiator: sequences S0-S7 around nDTACK and
// returns read data or a timeout error. Five cycles per zero-wait access.
module m68k_bus_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK_68KCLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WE,
  input  logic [22:0] ADDR,
  input  logic [1:0]  BE,
  input  logic [15:0] WDATA,
  output logic        READY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [22:0] A,
  output logic        nAS,
  output logic        nUDS,
  output logic        nLDS,
  output logic        RW,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic        nDTACK,
  input  logic [15:0] D_IN
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, S0, S2, S4, S6, S7} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [22:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic        idle_rdy, strobe_en;

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    err_d     = err_q;
    idle_rdy  = 1'b0;
    strobe_en = 1'b0;
    nAS       = 1'b1;
    D_OE      = 1'b0;
    DONE      = 1'b0;
    RW        = 1'b1;
    case (state_q)
      IDLE: begin
        // Hold off a new cycle until the slave has negated the last acknowledge.
        idle_rdy = nDTACK;
        if (REQ && nDTACK) begin
          we_d    = WE;
          addr_d  = ADDR;
          be_d    = (BE == 2'b00) ? 2'b11 : BE;
          wdata_d = WDATA;
          state_d = S0;
        end
      end
      S0: begin
        RW      = ~we_q;
        state_d = S2;
      end
      S2: begin
        RW        = ~we_q;
        nAS       = 1'b0;
        D_OE      = we_q;
        strobe_en = ~we_q;
        state_d   = S4;
      end
      S4: begin
        RW        = ~we_q;
        nAS       = 1'b0;
        D_OE      = we_q;
        strobe_en = 1'b1;
        if (!nDTACK) begin
          state_d = S6;
        end else if (wait_q == TO) begin
          err_d   = 1'b1;
          state_d = S7;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S6: begin
        RW        = ~we_q;
        nAS       = 1'b0;
        D_OE      = we_q;
        strobe_en = 1'b1;
        if (!we_q) rdata_d = D_IN;
        state_d = S7;
      end
      S7: begin
        RW      = ~we_q;
        DONE    = 1'b1;
        wait_d  = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign READY = idle_rdy & ~RESET;
  assign ERR   = DONE & err_q;
  assign RDATA = rdata_q;
  assign A     = addr_q;
  assign nUDS  = ~(strobe_en & be_q[1]);
  assign nLDS  = ~(strobe_en & be_q[0]);
  assign D_OUT = D_OE ? wdata_q : 16'h0000;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master (TIMEOUT = 4): read, write with waits,
// timeout, held acknowledge, mid-cycle reset, byte-enable default, back-to-back.
module tb_m68k_bus_master;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [22:0] addr;
  logic [1:0]  be;
  logic [15:0] wdata, d_in, rdata, d_out;
  logic        ready, done, err, n_as, n_uds, n_lds, rw, d_oe;
  logic [22:0] a;
  logic        dtack_drv, auto_dtack, n_dtack;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Zero-wait responder option: acknowledge follows the address strobe.
  assign n_dtack = auto_dtack ? n_as : dtack_drv;

  m68k_bus_master #(.TIMEOUT(4)) dut (
    .CLK_68KCLK(clk), .RESET(rst), .REQ(req), .WE(we), .ADDR(addr), .BE(be),
    .WDATA(wdata), .READY(ready), .DONE(done), .ERR(err), .RDATA(rdata),
    .A(a), .nAS(n_as), .nUDS(n_uds), .nLDS(n_lds), .RW(rw), .D_OUT(d_out),
    .D_OE(d_oe), .nDTACK(n_dtack), .D_IN(d_in)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    int done_cnt;
    logic [12:0] done_at, ready_at;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = 2'b11;
    wdata = '0; d_in = '0; dtack_drv = 1'b1; auto_dtack = 1'b0;
    tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_outs", {done, err, n_as, n_uds, n_lds, rw, d_oe}, 7'b0011110);
    chk("rst_a_dout", {a, d_out}, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0; #1;
    chk("idle_ready", ready, 1);

    // Zero-wait read
    req = 1'b1; we = 1'b0; addr = 23'h000100; be = 2'b11;
    tick();
    chk("rd_s0", {ready, n_as, rw, a}, {1'b0, 1'b1, 1'b1, 23'h000100});
    req = 1'b0; dtack_drv = 1'b0; d_in = 16'hBEEF;
    tick();
    chk("rd_s2", {n_as, n_uds, n_lds, d_oe}, 4'b0000);
    tick();
    chk("rd_s4", {n_as, n_uds, n_lds, done}, 4'b0000);
    tick();
    chk("rd_s6", {n_as, n_uds, n_lds, done}, 4'b0000);
    tick();
    chk("rd_s7", {done, err, n_as, n_uds, n_lds}, 5'b10111);
    chk("rd_data", rdata, 16'hBEEF);
    dtack_drv = 1'b1; d_in = 16'h5555;
    tick();
    chk("rd_idle", {ready, done, rw}, 3'b101);

    // Timeout: acknowledge never arrives
    req = 1'b1; addr = 23'h000200;
    tick();
    req = 1'b0;
    first = 0;
    for (int c = 2; c <= 15; c++) begin
      tick();
      if (done) begin
        first = c;
        chk("to_flags", {err, n_as, n_uds, n_lds}, 4'b1111);
        chk("to_rdata", rdata, 16'hBEEF);
        break;
      end
    end
    chk("to_done_cycle", first, 8);
    tick();

    // Write, three unacknowledged samples in S4
    req = 1'b1; we = 1'b1; be = 2'b01; wdata = 16'h1234; addr = 23'h000300;
    tick();
    chk("wr_s0", {rw, d_oe, n_as}, 3'b001);
    req = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (c == 6) dtack_drv = 1'b0;
      if (c == 2) chk("wr_s2", {d_oe, d_out, n_uds, n_lds, n_as}, {1'b1, 16'h1234, 3'b110});
      if (c == 3) chk("wr_s4", {n_uds, n_lds, rw}, 3'b100);
      if (c == 5) chk("wr_oe", {d_oe, done}, 2'b10);
      if (c == 7) chk("wr_s6", done, 0);
      if (c == 8) chk("wr_s7", {done, err, d_oe, n_as}, 4'b1001);
    end

    // Acknowledge still held after completion
    req = 1'b1; we = 1'b0; be = 2'b11; addr = 23'h000400;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("hold_blk", {ready, n_as, rw, a}, {3'b011, 23'h000300});
    end
    dtack_drv = 1'b1; #1;
    chk("hold_rel", ready, 1);
    tick();
    chk("hold_acc", {ready, a}, {1'b0, 23'h000400});
    req = 1'b0;
    tick(); dtack_drv = 1'b0;
    tick(); tick(); tick();
    chk("hold_done", {done, err}, 2'b10);
    dtack_drv = 1'b1;
    tick();

    // Reset while waiting in S4
    req = 1'b1; addr = 23'h000500;
    tick(); req = 1'b0;
    tick(); tick();
    chk("rs_in_s4", {n_as, n_uds}, 2'b00);
    rst = 1'b1;
    tick();
    chk("rs_outs", {n_as, n_uds, n_lds, d_oe, done, ready, rw}, 7'b1110001);
    chk("rs_a", a, 0);
    rst = 1'b0; #1;
    chk("rs_ready", ready, 1);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("rs_nodone", done_cnt, 0);

    // Byte enables of 00 act as a full word
    req = 1'b1; be = 2'b00; addr = 23'h000600;
    tick(); req = 1'b0; dtack_drv = 1'b0; d_in = 16'hCAFE;
    tick();
    chk("be00_strb", {n_uds, n_lds}, 2'b00);
    tick(); tick(); tick();
    chk("be00_done", {done, rdata}, {1'b1, 16'hCAFE});
    dtack_drv = 1'b1;
    tick();

    // Back-to-back with REQ held high and a zero-wait responder
    auto_dtack = 1'b1; be = 2'b11; req = 1'b1;
    done_at = '0; ready_at = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      done_at[c]  = done;
      ready_at[c] = ready;
    end
    chk("b2b_done", done_at, 13'b0_1000_0010_0000);
    chk("b2b_ready", ready_at, 13'b1_0000_0100_0000);
    req = 1'b0;
    first = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ready) begin
        first = 1;
        break;
      end
    end
    chk("b2b_drain", first, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
